// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte/state types, FSM encoding, forward S-box and check-code helpers
package aes_pkg;
  typedef logic [7:0] byte_t;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  localparam int NUM_BYTES = 16;
  localparam int CODE_W = 4;
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [CODE_W-1:0] check_code(byte_t y);
    return {^(y & 8'hdc), ^(y & 8'hf5), ^(y & 8'heb), ^(y & 8'hba)};
  endfunction
  // InvCode built by inverting the forward S-box, never from the inverse lookup table
  function automatic logic [256*CODE_W-1:0] inv_code_table();
    logic [256*CODE_W-1:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[CODE_W*int'(SBOX[i]) +: CODE_W] = check_code(byte_t'(i));
    return t;
  endfunction
endpackage

// File: rtl/inv_sbox_checked.sv
// inv_sbox_checked: combinational inverse S-box lookup with independently predicted check code
module inv_sbox_checked
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y,
  output logic [3:0] p
);
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  localparam logic [256*CODE_W-1:0] INV_CODE = inv_code_table();
  assign y = INV_SBOX[x];
  assign p = INV_CODE[{x, 2'b00} +: CODE_W];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes, LANES bytes per cycle, per-byte check-code error mask
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [15:0]  err_mask,
  output logic         err,
  input  logic         flt_en,
  input  logic [3:0]   flt_idx,
  input  logic [7:0]   flt_mask
);
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  st_t st, st_nxt;
  logic [3:0] idx;
  state_t src, res, res_nxt;
  logic [NUM_BYTES-1:0] msk, msk_nxt;
  logic last;
  logic [7:0] ly [LANES];
  logic [3:0] lb [LANES];
  logic [LANES-1:0] lerr;
  assign last = {1'b0, idx} + 5'(LANES) == 5'd16;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] y_raw;
    logic [CODE_W-1:0] p;
    assign lb[j] = idx + 4'(j);
    inv_sbox_checked u_sb (.x(src[8*lb[j] +: 8]), .y(y_raw), .p(p));
    assign ly[j] = y_raw ^ (flt_en && flt_idx == lb[j] ? flt_mask : 8'h00);
    assign lerr[j] = check_code(ly[j]) != p;
  end
  always_comb begin
    res_nxt = res;
    msk_nxt = msk;
    for (int k = 0; k < LANES; k++) begin
      res_nxt[8*lb[k] +: 8] = ly[k];
      msk_nxt[lb[k]] = lerr[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;
  always_comb
    st_nxt = st == IDLE ? (in_valid ? RUN : IDLE) :
             st == RUN  ? (last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = st == IDLE;
    out_valid = st == DONE;
  end
  assign err = |err_mask;
  // Working registers fill byte by byte; the visible outputs load only on entry to DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      src <= '0;
      res <= '0;
      msk <= '0;
      state_out <= '0;
      err_mask <= '0;
    end else begin
      if (st == IDLE && in_valid) begin
        src <= state_in;
        msk <= '0;
        idx <= '0;
      end
      if (st == RUN) begin
        res <= res_nxt;
        msk <= msk_nxt;
        idx <= idx + 4'(LANES);
        if (last) begin
          state_out <= res_nxt;
          err_mask <= msk_nxt;
        end
      end
    end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed checks of LANES=1 and LANES=4 instances driven in lockstep
module tb_inv_sub_bytes_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, flt_en = 0;
  logic [3:0] flt_idx = 0;
  logic [7:0] flt_mask = 0;
  logic [127:0] state_in = 0;
  logic in_ready1, out_valid1, err1, in_ready4, out_valid4, err4;
  logic [127:0] state_out1, state_out4;
  logic [15:0] err_mask1, err_mask4;
  int checks = 0, errors = 0;
  int lat1, lat4;
  logic [127:0] got1, got4, s, e;
  logic [15:0] m1, m4;
  logic e1, e4;
  logic [7:0] inv [256];
  logic [7:0] fwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .state_in(state_in),
    .out_valid(out_valid1), .out_ready(out_ready), .state_out(state_out1), .err_mask(err_mask1),
    .err(err1), .flt_en(flt_en), .flt_idx(flt_idx), .flt_mask(flt_mask)
  );
  inv_sub_bytes_seq #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .state_in(state_in),
    .out_valid(out_valid4), .out_ready(out_ready), .state_out(state_out4), .err_mask(err_mask4),
    .err(err4), .flt_en(flt_en), .flt_idx(flt_idx), .flt_mask(flt_mask)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] gold(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv[x[8*i +: 8]];
    return r;
  endfunction

  task automatic send(input logic [127:0] x);
    @(negedge clk);
    for (int c = 0; c < 40 && !(in_ready1 && in_ready4); c++) @(negedge clk);
    state_in = x;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat1 = 0;
    lat4 = 0;
    for (int c = 1; c <= 40 && (lat1 == 0 || lat4 == 0); c++) begin
      @(posedge clk);
      #1;
      if (out_valid4 && lat4 == 0) begin lat4 = c; got4 = state_out4; m4 = err_mask4; e4 = err4; end
      if (out_valid1 && lat1 == 0) begin lat1 = c; got1 = state_out1; m1 = err_mask1; e1 = err1; end
    end
  endtask

  task automatic txn(input string tag, input logic [127:0] x, input logic [127:0] exp, input logic [15:0] em);
    send(x);
    chk({tag, " lat1"}, 128'(lat1), 128'd16);
    chk({tag, " lat4"}, 128'(lat4), 128'd4);
    chk({tag, " out1"}, got1, exp);
    chk({tag, " out4"}, got4, exp);
    chk({tag, " mask1"}, 128'(m1), 128'(em));
    chk({tag, " mask4"}, 128'(m4), 128'(em));
    chk({tag, " err1"}, 128'(e1), 128'(|em));
    chk({tag, " err4"}, 128'(e4), 128'(|em));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 128'(in_ready1), 128'd1);
    chk("rst out_valid", 128'(out_valid1), 128'd0);
    chk("rst state_out", state_out1, 128'd0);
    chk("rst err_mask", 128'(err_mask1), 128'd0);
    chk("rst err", 128'(err1), 128'd0);
    @(negedge clk) rst_n = 1;
    txn("all63", {16{8'h63}}, 128'd0, 16'h0000);
    txn("pattern", {4{32'h167c0063}}, {4{32'hff015200}}, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16*k + i);
      txn($sformatf("sweep%0d", k), s, gold(s), 16'h0000);
    end
    s = 128'h00112233_44556677_8899aabb_ccddeeff;
    flt_en = 1;
    flt_idx = 4'd5;
    flt_mask = 8'h01;
    txn("fault", s, gold(s) ^ (128'h1 << 40), 16'h0020);
    flt_en = 0;
    txn("nofault", s, gold(s), 16'h0000);
    @(posedge clk);
    #1 out_ready = 0;
    s = {4{32'h167c0063}};
    send(s);
    chk("hold lat1", 128'(lat1), 128'd16);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("hold out_valid", 128'(out_valid1), 128'd1);
      chk("hold state_out", state_out1, {4{32'hff015200}});
      chk("hold err_mask", 128'(err_mask1), 128'd0);
      chk("hold in_ready", 128'({in_ready1, in_ready4}), 128'd0);
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1;
    chk("release out_valid", 128'({out_valid1, out_valid4}), 128'd0);
    chk("release in_ready", 128'({in_ready1, in_ready4}), 128'd3);
    @(negedge clk);
    state_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (7) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort out_valid", 128'(out_valid1), 128'd0);
    chk("abort in_ready", 128'(in_ready1), 128'd1);
    chk("abort state_out", state_out1, 128'd0);
    chk("abort err_mask", 128'(err_mask1), 128'd0);
    @(negedge clk) rst_n = 1;
    s = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    txn("after_abort", s, gold(s), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
